alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the 16-bit combinational datapath ALU. Adds configurable width, an extended op set, signed N/V flags next to Z, and a valid/ready handshake on both sides. A committed status register captures the flags of each consumed result. It sits between the register-file read ports and the writeback mux, and lets the controller stall writeback without losing results.

---
 rtl/alu_pipe.sv | 131 +++++++++++++
 tb/tb_alu_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, signed N/V/Z flags
// and a status register holding the flags of the last consumed result.
`timescale 1ns/1ps

module alu_pipe #(
    parameter int WIDTH   = 16,
    parameter int EXT_OPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic [2:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic [2:0]       status
);

    logic             init_done_reg;
    logic             s1_valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             z_reg;
    logic             n_reg;
    logic             v_reg;
    logic [2:0]       status_reg;

    logic             advance;
    logic             accept;
    logic             consume;

    logic [2:0]       op_next;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH-1:0] res_next;
    logic             v_next;

    // Stage 1 hands over whenever the output slot is empty or being drained.
    assign advance  = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = init_done_reg && (!s1_valid_reg || advance);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_reg && out_ready;

    always_comb begin
        op_next   = op_reg;
        if (EXT_OPS == 0 && op_reg[2]) begin
            op_next = 3'b000;
        end
        sum_next  = a_reg + b_reg;
        diff_next = a_reg - b_reg;
        res_next  = sum_next;
        v_next    = 1'b0;
        case (op_next)
            3'b000: begin
                res_next = sum_next;
                v_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
            3'b001: begin
                res_next = diff_next;
                v_next   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                           (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
            end
            3'b010:  res_next = a_reg & b_reg;
            3'b011:  res_next = ~b_reg;
            3'b100:  res_next = a_reg | b_reg;
            3'b101:  res_next = a_reg ^ b_reg;
            3'b110:  res_next = {a_reg[WIDTH-2:0], 1'b0};
            default: res_next = {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= 3'b000;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            z_reg         <= 1'b0;
            n_reg         <= 1'b0;
            v_reg         <= 1'b0;
            status_reg    <= 3'b000;
        end else begin
            init_done_reg <= 1'b1;
            if (accept) begin
                s1_valid_reg <= 1'b1;
                a_reg        <= ain;
                b_reg        <= bin;
                op_reg       <= alu_op;
            end else if (advance) begin
                s1_valid_reg <= 1'b0;
            end

            // Result registers only move on advance, so they hold under backpressure.
            if (advance) begin
                out_valid_reg <= 1'b1;
                out_reg       <= res_next;
                z_reg         <= (res_next == '0);
                n_reg         <= res_next[WIDTH-1];
                v_reg         <= v_next;
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end

            if (consume) begin
                status_reg <= {n_reg, v_reg, z_reg};
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign z         = z_reg;
    assign n         = n_reg;
    assign v         = v_reg;
    assign status    = status_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against an arithmetic reference model,
// plus a narrow WIDTH=8 / EXT_OPS=0 instance for the reduced op set.
`timescale 1ns/1ps

module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [2:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        z, n, v;
    logic [2:0]  status;

    logic        e_in_valid;
    logic        e_in_ready;
    logic [7:0]  e_ain;
    logic [7:0]  e_bin;
    logic [2:0]  e_op;
    logic        e_out_valid;
    logic        e_out_ready;
    logic [7:0]  e_out;
    logic        e_z, e_n, e_v;
    logic [2:0]  e_status;

    int checks   = 0;
    int failures = 0;

    logic [18:0] q[$];          // expected {n,v,z,out} of in-flight ops, oldest first
    logic [2:0]  exp_status;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16), .EXT_OPS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ain(ain), .bin(bin), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(dout), .z(z), .n(n), .v(v), .status(status)
    );

    alu_pipe #(.WIDTH(8), .EXT_OPS(0)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(e_in_valid), .in_ready(e_in_ready),
        .ain(e_ain), .bin(e_bin), .alu_op(e_op),
        .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out(e_out), .z(e_z), .n(e_n), .v(e_v), .status(e_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic reduced modulo 2^w. Returns {n,v,z,result}.
    function automatic logic [34:0] ref_alu(input longint a, input longint b,
                                            input int op_in, input int w, input bit ext);
        longint m, half, sa, sb, r;
        int     op;
        logic   ovf;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        op   = (!ext && op_in >= 4) ? 0 : op_in;
        ovf  = 1'b0;
        case (op)
            0: begin r = sa + sb; ovf = (r >= half) || (r < -half); end
            1: begin r = sa - sb; ovf = (r >= half) || (r < -half); end
            2: r = a & b;
            3: r = (m - 1) - b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = a * 2;
            default: r = (sa < 0) ? -((1 - sa) / 2) : sa / 2;
        endcase
        r = ((r % m) + m) % m;
        return {(r >= half), ovf, (r == 0), r[31:0]};
    endfunction

    // One clock of the 16-bit interface; scores every output seen and every accept.
    task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic ordy, output logic acc);
        logic [34:0] e;
        @(negedge clk);
        in_valid  = iv;
        ain       = a;
        bin       = b;
        alu_op    = op;
        out_ready = ordy;
        #1;
        check("status", {29'd0, status}, {29'd0, exp_status});
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                check("out", {16'd0, dout}, {16'd0, q[0][15:0]});
                check("flags", {29'd0, n, v, z}, {29'd0, q[0][18:16]});
                if (ordy) begin
                    $display("consume out=%h nvz=%b", dout, {n, v, z});
                    exp_status = q[0][18:16];
                    void'(q.pop_front());
                end
            end
        end
        acc = iv && in_ready;
        if (acc) begin
            e = ref_alu(longint'(a), longint'(b), int'(op), 16, 1'b1);
            q.push_back({e[34:32], e[15:0]});
            $display("accept a=%h b=%h op=%0d", a, b, op);
            check("inflight_le2", {31'd0, q.size() <= 2}, 32'd1);
        end
    endtask

    task automatic idle(input int cnt);
        logic acc;
        for (int i = 0; i < cnt; i++) cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_clk", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic e_run(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [10:0] gold);
        logic [34:0] e;
        bit          seen;
        e = ref_alu(longint'(a), longint'(b), int'(op), 8, 1'b0);
        @(negedge clk);
        e_in_valid = 1'b1; e_ain = a; e_bin = b; e_op = op; e_out_ready = 1'b1;
        #1;
        check("e_in_ready", {31'd0, e_in_ready}, 32'd1);
        @(negedge clk);
        e_in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            #1;
            if (e_out_valid) begin
                seen = 1'b1;
                $display("e8 a=%h b=%h op=%0d out=%h nvz=%b", a, b, op, e_out, {e_n, e_v, e_z});
                check("e_out", {24'd0, e_out}, {24'd0, e[7:0]});
                check("e_flags", {29'd0, e_n, e_v, e_z}, {29'd0, e[34:32]});
                check("e_gold", {21'd0, e_n, e_v, e_z, e_out}, {21'd0, gold});
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check("e_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        check("e_status", {29'd0, e_status}, {29'd0, e[34:32]});
    endtask

    logic [15:0] vec_a [11] = '{16'h7FFF, 16'h0000, 16'd100, 16'h0000, 16'h8000, 16'h6F02,
                                16'h1234, 16'h8004, 16'h00F0, 16'hFFFF, 16'h4001};
    logic [15:0] vec_b [11] = '{16'h0001, 16'h0000, 16'd24, 16'h0001, 16'h0001, 16'hA6CB,
                                16'h8E38, 16'h0000, 16'h0F00, 16'hFFFF, 16'h0000};
    logic [2:0]  vec_op[11] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6};
    logic [18:0] vec_g [11] = '{{3'b110, 16'h8000}, {3'b001, 16'h0000}, {3'b000, 16'h004C},
                                {3'b100, 16'hFFFF}, {3'b010, 16'h7FFF}, {3'b000, 16'h2602},
                                {3'b000, 16'h71C7}, {3'b100, 16'hC002}, {3'b000, 16'h0FF0},
                                {3'b001, 16'h0000}, {3'b100, 16'h8002}};

    initial begin
        logic        acc;
        logic [15:0] ra, rb;
        int          guard;

        rst_n = 1'b0;
        in_valid = 1'b0; ain = '0; bin = '0; alu_op = '0; out_ready = 1'b0;
        e_in_valid = 1'b0; e_ain = '0; e_bin = '0; e_op = '0; e_out_ready = 1'b0;
        exp_status = 3'b000;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {16'd0, dout}, 32'd0);
        check("rst_flags", {29'd0, n, v, z}, 32'd0);
        check("rst_status", {29'd0, status}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        release_reset();

        // Directed vectors: result visible exactly two cycles after the accept cycle.
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, vec_a[i], vec_b[i], vec_op[i], 1'b1, acc);
            check("dir_accept", {31'd0, acc}, 32'd1);
            cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            check("lat_early", {31'd0, out_valid}, 32'd0);
            cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("gold", {13'd0, n, v, z, dout}, {13'd0, vec_g[i]});
        end
        idle(2);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_hold", {16'd0, dout}, {16'd0, vec_g[10][15:0]});

        // Back-to-back stream under backpressure.
        cycle(1'b1, 16'h0011, 16'h0022, 3'd0, 1'b0, acc);
        check("bp_acc1", {31'd0, acc}, 32'd1);
        cycle(1'b1, 16'h0100, 16'h0001, 3'd1, 1'b0, acc);
        check("bp_acc2", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'h8000, 16'h8000, 3'd0, 1'b0, acc);
            check("bp_third_blocked", {31'd0, acc}, 32'd0);
            check("bp_hold_first", {16'd0, dout}, 32'h0033);
        end
        cycle(1'b1, 16'h8000, 16'h8000, 3'd0, 1'b1, acc);
        check("bp_release_acc", {31'd0, acc}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        check("bp_second", {31'd0, out_valid}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        check("bp_third", {31'd0, out_valid}, 32'd1);
        cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_queue", q.size(), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            cycle(($urandom_range(0, 3) != 0), ra, rb, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) != 0), acc);
        end
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 20) begin
            cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            guard++;
        end
        check("rand_drained", q.size(), 32'd0);

        // Reset with ops in both stages: everything discarded at once.
        cycle(1'b1, 16'h7FFF, 16'h0001, 3'd0, 1'b1, acc);
        idle(3);
        cycle(1'b1, 16'h1234, 16'h0001, 3'd0, 1'b0, acc);
        cycle(1'b1, 16'h5555, 16'h0001, 3'd0, 1'b0, acc);
        cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, acc);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out", {16'd0, dout}, 32'd0);
        check("mid_rst_status", {29'd0, status}, 32'd0);
        check("mid_rst_flags", {29'd0, n, v, z}, 32'd0);
        q.delete();
        exp_status = 3'b000;
        @(posedge clk);
        release_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end

        // Narrow instance without extended ops.
        e_run(8'h7F, 8'h01, 3'd0, {3'b110, 8'h80});
        e_run(8'h03, 8'h05, 3'd5, {3'b000, 8'h08});
        e_run(8'h10, 8'h01, 3'd7, {3'b000, 8'h11});
        e_run(8'h05, 8'h05, 3'd1, {3'b001, 8'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
